uc_bcast_queue: RTL and testbench

Parametrised broadcast queue between the unit-clause arbiter and the per-engine UCQ_out inputs. Each literal pushed by the arbiter is delivered once to every one of `NUM_CONS` consumers; each consumer drains at its own pace through an independent valid/ready port. A slot is reclaimed only after all consumers have popped it. The block replaces the single-pointer mstack, which could not track per-engine progress. It adds a flush for conflict and backtrack handling, and an occupancy output.

---
 rtl/uc_bcast_queue.sv | 103 ++++++++++
 tb/tb_uc_bcast_queue.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_bcast_queue.sv
// Broadcast queue: every pushed literal is delivered once to each of NUM_CONS
// consumers; a slot is reclaimed only after all consumers have popped it.
module uc_bcast_queue #(
   parameter int unsigned LIT_W    = 16,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned NUM_CONS = 4,
   parameter int unsigned AW       = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      push,
   input  logic [LIT_W-1:0]          push_lit,
   output logic                      full,
   output logic                      empty,
   output logic [AW:0]               count,
   output logic                      overflow,
   output logic [NUM_CONS-1:0]       cons_valid,
   input  logic [NUM_CONS-1:0]       cons_ready,
   output logic [NUM_CONS*LIT_W-1:0] cons_lit
);

   localparam int unsigned PW = AW + 1;

   logic [LIT_W-1:0]    mem_q  [DEPTH];
   logic [LIT_W-1:0]    mem_d  [DEPTH];
   logic [NUM_CONS-1:0] pend_q [DEPTH];
   logic [NUM_CONS-1:0] pend_d [DEPTH];
   logic [AW:0]         wr_ptr_q, wr_ptr_d;
   logic [AW:0]         tail_ptr_q, tail_ptr_d;
   logic [AW:0]         rd_ptr_q [NUM_CONS];
   logic [AW:0]         rd_ptr_d [NUM_CONS];
   logic                overflow_q, overflow_d;

   assign count    = wr_ptr_q - tail_ptr_q;
   assign full     = (count == PW'(DEPTH));
   assign empty    = (count == '0);
   assign overflow = overflow_q;

   // Per-consumer head: valid while the consumer lags the writer.
   always_comb begin
      cons_valid = '0;
      cons_lit   = '0;
      for (int i = 0; i < NUM_CONS; i++) begin
         cons_valid[i]              = (rd_ptr_q[i] != wr_ptr_q);
         cons_lit[i*LIT_W +: LIT_W] = mem_q[rd_ptr_q[i][AW-1:0]];
      end
   end

   // Next state: flush overrides push, pops and reclaim in the same cycle.
   always_comb begin
      mem_d      = mem_q;
      pend_d     = pend_q;
      wr_ptr_d   = wr_ptr_q;
      tail_ptr_d = tail_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (flush) begin
         wr_ptr_d   = '0;
         tail_ptr_d = '0;
         for (int i = 0; i < NUM_CONS; i++) rd_ptr_d[i] = '0;
         for (int s = 0; s < DEPTH; s++) pend_d[s] = '0;
      end else begin
         if (push && full) overflow_d = 1'b1;
         // Reclaim looks at registered pend, so a final pop frees its slot one edge later.
         if ((tail_ptr_q != wr_ptr_q) && (pend_q[tail_ptr_q[AW-1:0]] == '0))
            tail_ptr_d = tail_ptr_q + PW'(1);
         for (int i = 0; i < NUM_CONS; i++) begin
            if (cons_valid[i] && cons_ready[i]) begin
               pend_d[rd_ptr_q[i][AW-1:0]][i] = 1'b0;
               rd_ptr_d[i]                     = rd_ptr_q[i] + PW'(1);
            end
         end
         if (push && !full) begin
            mem_d[wr_ptr_q[AW-1:0]]  = push_lit;
            pend_d[wr_ptr_q[AW-1:0]] = '1;
            wr_ptr_d                 = wr_ptr_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         tail_ptr_q <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < NUM_CONS; i++) rd_ptr_q[i] <= '0;
         for (int s = 0; s < DEPTH; s++) pend_q[s] <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         tail_ptr_q <= tail_ptr_d;
         overflow_q <= overflow_d;
         rd_ptr_q   <= rd_ptr_d;
         pend_q     <= pend_d;
      end
   end

   // Literal storage carries no reset; stale contents are masked by cons_valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_uc_bcast_queue.sv
// Bench for uc_bcast_queue (DEPTH=4, NUM_CONS=2): vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_uc_bcast_queue;

   localparam int unsigned LW = 8;
   localparam int unsigned DP = 4;
   localparam int unsigned NC = 2;
   localparam int unsigned AW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          push = 1'b0;
   logic [LW-1:0] push_lit = '0;
   logic          full, empty, overflow;
   logic [AW:0]   count;
   logic [NC-1:0] cons_valid;
   logic [NC-1:0] cons_ready = '0;
   logic [NC*LW-1:0] cons_lit;

   int total = 0;
   int bad   = 0;

   uc_bcast_queue #(.LIT_W(LW), .DEPTH(DP), .NUM_CONS(NC)) dut (
      .clk(clk), .rst(rst), .flush(flush), .push(push), .push_lit(push_lit),
      .full(full), .empty(empty), .count(count), .overflow(overflow),
      .cons_valid(cons_valid), .cons_ready(cons_ready), .cons_lit(cons_lit)
   );

   always #5 clk = ~clk;

   // Reference model: resident literals in arrival order, each with the set of
   // consumers still owing a read, and each consumer's offset from the oldest.
   logic [LW-1:0] m_lit[$];
   logic [NC-1:0] m_pend[$];
   int            m_rd[NC];
   bit            m_ovf;

   bit            rec_en = 1'b0;
   logic [LW-1:0] rec0[$];
   logic [LW-1:0] rec1[$];

   typedef struct {
      logic          p;
      logic [LW-1:0] l;
      logic          f;
      logic [NC-1:0] r;
      int            cnt;
      logic [NC-1:0] val;
      logic [LW-1:0] l0;
      logic [LW-1:0] l1;
      logic          ovf;
   } vec_t;
   vec_t tv[$];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic add(input logic p, input logic [LW-1:0] l, input logic f,
                      input logic [NC-1:0] r, input int cnt, input logic [NC-1:0] val,
                      input logic [LW-1:0] l0, input logic [LW-1:0] l1, input logic ovf);
      vec_t v;
      v.p = p; v.l = l; v.f = f; v.r = r; v.cnt = cnt;
      v.val = val; v.l0 = l0; v.l1 = l1; v.ovf = ovf;
      tv.push_back(v);
   endtask

   task automatic model_reset(input bit clr_ovf);
      m_lit.delete();
      m_pend.delete();
      for (int i = 0; i < NC; i++) m_rd[i] = 0;
      if (clr_ovf) m_ovf = 1'b0;
   endtask

   task automatic model_edge(input logic p, input logic [LW-1:0] l,
                             input logic [NC-1:0] r, input logic f);
      int  sz;
      bit  recl;
      logic [NC-1:0] pe;
      if (f) begin
         model_reset(1'b0);
         return;
      end
      sz   = m_lit.size();
      recl = (sz > 0) && (m_pend[0] == '0);
      for (int i = 0; i < NC; i++) begin
         if (m_rd[i] < sz && r[i]) begin
            pe = m_pend[m_rd[i]];
            pe[i] = 1'b0;
            m_pend[m_rd[i]] = pe;
            m_rd[i]++;
         end
      end
      if (p) begin
         if (sz < DP) begin
            m_lit.push_back(l);
            m_pend.push_back('1);
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (recl) begin
         void'(m_lit.pop_front());
         void'(m_pend.pop_front());
         for (int i = 0; i < NC; i++) m_rd[i]--;
      end
   endtask

   task automatic step(input logic p, input logic [LW-1:0] l,
                       input logic [NC-1:0] r, input logic f);
      push = p; push_lit = l; cons_ready = r; flush = f;
      if (rec_en) begin
         if (cons_valid[0] && r[0]) rec0.push_back(cons_lit[0 +: LW]);
         if (cons_valid[1] && r[1]) rec1.push_back(cons_lit[LW +: LW]);
      end
      @(posedge clk);
      model_edge(p, l, r, f);
      #1;
   endtask

   task automatic check_model();
      int sz;
      sz = m_lit.size();
      chk("m_count", int'(count), sz);
      chk("m_full", int'(full), int'(sz == DP));
      chk("m_empty", int'(empty), int'(sz == 0));
      chk("m_overflow", int'(overflow), int'(m_ovf));
      for (int i = 0; i < NC; i++) begin
         chk("m_valid", int'(cons_valid[i]), int'(m_rd[i] < sz));
         if (m_rd[i] < sz) chk("m_lit", int'(cons_lit[i*LW +: LW]), int'(m_lit[m_rd[i]]));
      end
   endtask

   initial begin
      m_ovf = 1'b0;
      model_reset(1'b1);

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_count", int'(count), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_valid", int'(cons_valid), 0);
      rst = 1'b0;

      // Broadcast ordering; third row is push + two pops + reclaim together
      add(1, 8'h11, 0, 2'b11, 1, 2'b11, 8'h11, 8'h11, 0);
      add(1, 8'h22, 0, 2'b11, 2, 2'b11, 8'h22, 8'h22, 0);
      add(1, 8'h33, 0, 2'b11, 2, 2'b11, 8'h33, 8'h33, 0);
      add(0, 8'h00, 0, 2'b11, 1, 2'b00, 8'h00, 8'h00, 0);
      add(0, 8'h00, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 0);
      // Skewed consumers, full, overflow, 2-edge reclaim
      add(1, 8'hA1, 0, 2'b10, 1, 2'b11, 8'hA1, 8'hA1, 0);
      add(1, 8'hA2, 0, 2'b10, 2, 2'b11, 8'hA1, 8'hA2, 0);
      add(1, 8'hA3, 0, 2'b10, 3, 2'b11, 8'hA1, 8'hA3, 0);
      add(1, 8'hA4, 0, 2'b10, 4, 2'b11, 8'hA1, 8'hA4, 0);
      add(1, 8'hA5, 0, 2'b10, 4, 2'b01, 8'hA1, 8'h00, 1);
      add(0, 8'h00, 0, 2'b10, 4, 2'b01, 8'hA1, 8'h00, 1);
      add(0, 8'h00, 0, 2'b11, 4, 2'b01, 8'hA2, 8'h00, 1);
      add(0, 8'h00, 0, 2'b11, 3, 2'b01, 8'hA3, 8'h00, 1);
      add(0, 8'h00, 0, 2'b11, 2, 2'b01, 8'hA4, 8'h00, 1);
      add(0, 8'h00, 0, 2'b11, 1, 2'b00, 8'h00, 8'h00, 1);
      add(0, 8'h00, 0, 2'b11, 0, 2'b00, 8'h00, 8'h00, 1);
      // Flush with a concurrent push and pops
      add(1, 8'h01, 0, 2'b00, 1, 2'b11, 8'h01, 8'h01, 1);
      add(1, 8'h02, 0, 2'b00, 2, 2'b11, 8'h01, 8'h01, 1);
      add(1, 8'h03, 0, 2'b00, 3, 2'b11, 8'h01, 8'h01, 1);
      add(1, 8'h7F, 1, 2'b11, 0, 2'b00, 8'h00, 8'h00, 1);
      add(1, 8'h55, 0, 2'b00, 1, 2'b11, 8'h55, 8'h55, 1);
      add(0, 8'h00, 1, 2'b00, 0, 2'b00, 8'h00, 8'h00, 1);

      foreach (tv[k]) begin
         step(tv[k].p, tv[k].l, tv[k].r, tv[k].f);
         chk($sformatf("v%0d_count", k), int'(count), tv[k].cnt);
         chk($sformatf("v%0d_full", k), int'(full), int'(tv[k].cnt == DP));
         chk($sformatf("v%0d_empty", k), int'(empty), int'(tv[k].cnt == 0));
         chk($sformatf("v%0d_valid", k), int'(cons_valid), int'(tv[k].val));
         chk($sformatf("v%0d_ovf", k), int'(overflow), int'(tv[k].ovf));
         if (tv[k].val[0]) chk($sformatf("v%0d_lit0", k), int'(cons_lit[0 +: LW]), int'(tv[k].l0));
         if (tv[k].val[1]) chk($sformatf("v%0d_lit1", k), int'(cons_lit[LW +: LW]), int'(tv[k].l1));
      end

      // Asynchronous reset mid-burst, with overflow still set
      step(1, 8'h31, 2'b11, 0);
      step(1, 8'h32, 2'b11, 0);
      step(1, 8'h33, 2'b11, 0);
      #3 rst = 1'b1;
      #1;
      chk("arst_count", int'(count), 0);
      chk("arst_full", int'(full), 0);
      chk("arst_empty", int'(empty), 1);
      chk("arst_overflow", int'(overflow), 0);
      chk("arst_valid", int'(cons_valid), 0);
      push = 1'b0; cons_ready = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset(1'b1);
      step(1, 8'h99, 2'b00, 0);
      chk("arst_first_valid", int'(cons_valid), 3);
      chk("arst_first_lit0", int'(cons_lit[0 +: LW]), 8'h99);
      chk("arst_first_lit1", int'(cons_lit[LW +: LW]), 8'h99);
      repeat (3) step(0, 8'h00, 2'b11, 0);
      chk("arst_drained", int'(count), 0);

      // Wrap-around stream of 20 literals
      rec_en = 1'b1;
      for (int k = 0; k < 20; k++) step(1, LW'(k), 2'b11, 0);
      repeat (4) step(0, 8'h00, 2'b11, 0);
      rec_en = 1'b0;
      chk("wrap_n0", rec0.size(), 20);
      chk("wrap_n1", rec1.size(), 20);
      for (int k = 0; k < 20; k++) begin
         if (k < rec0.size()) chk($sformatf("wrap0_%0d", k), int'(rec0[k]), k);
         if (k < rec1.size()) chk($sformatf("wrap1_%0d", k), int'(rec1[k]), k);
      end
      chk("wrap_ovf", int'(overflow), 0);
      check_model();

      // Randomized traffic against the reference model
      for (int c = 0; c < 600; c++) begin
         logic          p, f;
         logic [LW-1:0] l;
         logic [NC-1:0] r;
         p = ($urandom_range(0, 99) < 55);
         f = ($urandom_range(0, 99) < 3);
         l = LW'($urandom);
         r = NC'($urandom_range(0, 3));
         step(p, l, r, f);
         check_model();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
